// File: rtl/sensor_poll_pkg.sv
// rtl/sensor_poll_pkg.sv - shared constants and helpers for the sensor polling scheduler
package sensor_poll_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SELECT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_TX = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_RX = 3'd4;
  localparam logic [STATE_W-1:0] ST_CHECK   = 3'd5;
  localparam logic [STATE_W-1:0] ST_REPORT  = 3'd6;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  // Counter/index width for n distinct values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_poll_if.sv
// rtl/sensor_poll_if.sv - UART TX/RX and checksum signals shared with the poll controller
interface sensor_poll_if;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_active;
  logic        tx_done;
  logic [15:0] rx_data;
  logic        rx_done;
  logic        crc_ok;

  modport master (
    output tx_data, tx_enable,
    input  tx_active, tx_done, rx_data, rx_done, crc_ok
  );

  modport slave (
    input  tx_data, tx_enable,
    output tx_active, tx_done, rx_data, rx_done, crc_ok
  );
endinterface

// File: rtl/sensor_rr_pick.sv
// rtl/sensor_rr_pick.sv - combinational round-robin picker: first enabled index after ptr
module sensor_rr_pick
  import sensor_poll_pkg::*;
#(
  parameter int NUM_SENSORS = 8,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_SENSORS-1:0] en,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest enabled index after ptr is the last write.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_SENSORS);
      if (en[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_poll_ctrl.sv
// rtl/sensor_poll_ctrl.sv - round-robin sensor poller with checksum/timeout retry and result reporting
module sensor_poll_ctrl
  import sensor_poll_pkg::*;
#(
  parameter int NUM_SENSORS    = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_SENSORS-1:0] sensor_en,
  sensor_poll_if.master          uart,
  output logic                   busy,
  output logic                   result_valid,
  output logic [7:0]             result_sensor,
  output logic [7:0]             result_data,
  output logic                   result_error,
  output logic [7:0]             err_count
);

  localparam int IDX_W = idx_w(NUM_SENSORS);
  localparam int TMR_W = idx_w(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = idx_w(MAX_RETRY + 1);

  logic [STATE_W-1:0] state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [TMR_W-1:0]   timer;
  logic [RTY_W-1:0]   retry;
  logic [7:0]         tx_q;
  logic [7:0]         data_q;
  logic               crc_q;
  logic               timeout;
  logic               unused_ok;

  sensor_rr_pick #(
    .NUM_SENSORS (NUM_SENSORS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .en  (sensor_en),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Timer may pass the limit by one when tx_done lands on the last cycle, hence >=.
  assign timeout        = (timer >= TMR_W'(TIMEOUT_CYCLES - 1));
  assign uart.tx_data   = tx_q;
  assign uart.tx_enable = (state == ST_SEND);
  assign busy           = (state != ST_IDLE);
  assign result_valid   = (state == ST_REPORT);
  assign unused_ok      = ^{uart.tx_active, uart.rx_data[15:8]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ptr           <= IDX_W'(NUM_SENSORS - 1);
      timer         <= '0;
      retry         <= '0;
      tx_q          <= '0;
      data_q        <= '0;
      crc_q         <= 1'b0;
      result_sensor <= '0;
      result_data   <= '0;
      result_error  <= 1'b0;
      err_count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run && |sensor_en) state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (pick_any) begin
            ptr   <= pick_idx;
            tx_q  <= 8'(pick_idx);
            retry <= '0;
            state <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          timer <= '0;
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          timer <= timer + 1'b1;
          if (uart.tx_done) begin
            state <= ST_WAIT_RX;
          end else if (timeout) begin
            crc_q <= 1'b0;
            state <= ST_CHECK;
          end
        end
        ST_WAIT_RX: begin
          timer <= timer + 1'b1;
          if (uart.rx_done) begin
            data_q <= uart.rx_data[7:0];
            crc_q  <= uart.crc_ok;
            state  <= ST_CHECK;
          end else if (timeout) begin
            crc_q <= 1'b0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!crc_q && (retry < RTY_W'(MAX_RETRY))) begin
            retry <= retry + 1'b1;
            state <= ST_SEND;
          end else begin
            result_sensor <= 8'(ptr);
            result_data   <= data_q;
            result_error  <= !crc_q;
            state         <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (result_error && (err_count != ERR_SAT)) err_count <= err_count + 8'd1;
          state <= (run && |sensor_en) ? ST_SELECT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sensor_poll_ctrl.md
Name: sensor_poll_ctrl

Overview:
Round-robin polling scheduler that drives the shared UART transmitter and receiver for the sensor bus. For each enabled sensor it sends a 1-byte request (the sensor index) and waits for a 2-byte reply (data + checksum). It checks the reply against the checksum verdict, retries on checksum error or timeout, and reports one result per sensor. It sits between the UART TX/RX/checksum instances and the host-side logic; it replaces ad-hoc state sequencing around those blocks.

Parameters:
NUM_SENSORS, 8, number of pollable sensors (2..256)
TIMEOUT_CYCLES, 50000, clock cycles from request pulse until a reply counts as missing
MAX_RETRY, 2, extra attempts per sensor after the first failed one

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
run  input  1  level; 1 = keep polling, 0 = stop after the current transaction
sensor_en  input  NUM_SENSORS  per-sensor poll enable; sampled only in SELECT
tx_data  output  8  request byte to UART TX (zero-extended sensor index)
tx_enable  output  1  one-cycle start pulse to UART TX
tx_active  input  1  UART TX busy; informational, not used for sequencing
tx_done  input  1  UART TX byte-complete pulse
rx_data  input  16  UART RX word; [7:0] = data, [15:8] = checksum
rx_done  input  1  UART RX 2-byte-complete pulse
crc_ok  input  1  combinational checksum verdict for the current rx_data
busy  output  1  high in every state except IDLE
result_valid  output  1  one-cycle pulse; result_* fields valid only in that cycle
result_sensor  output  8  polled sensor index
result_data  output  8  rx_data[7:0] of the final attempt
result_error  output  1  1 = all attempts failed (checksum error or timeout)
err_count  output  8  saturating count of result_error pulses

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE. tx_enable=0, tx_data=0, busy=0, result_valid=0, result_sensor=0, result_data=0, result_error=0, err_count=0, retry=0, timer=0. Round-robin pointer = NUM_SENSORS-1, so the first poll selects sensor 0. Reset aborts any in-flight transaction; a later stray tx_done/rx_done is ignored.
- States: IDLE, SELECT, SEND, WAIT_TX, WAIT_RX, CHECK, REPORT.
- IDLE: if run=1 and |sensor_en, go to SELECT; otherwise stay.
- SELECT (1 cycle): idx = first enabled index searching ptr+1, ptr+2, … with wrap. Then ptr<=idx, tx_data<=idx, retry<=0, go to SEND. If sensor_en became 0, go to IDLE.
- SEND (1 cycle): tx_enable=1, timer<=0, go to WAIT_TX.
- WAIT_TX: on tx_done, go to WAIT_RX. The timer runs from SEND onward.
- WAIT_RX: on rx_done, capture data_q<=rx_data[7:0] and crc_q<=crc_ok in the same cycle, then go to CHECK.
- Timeout: in WAIT_TX or WAIT_RX, timer==TIMEOUT_CYCLES-1 with no completing pulse counts as a failed attempt. If rx_done and timeout occur in the same cycle, rx_done wins.
- CHECK (1 cycle):
  - crc_q=1: go to REPORT with error=0.
  - Failure and retry<MAX_RETRY: retry++, go to SEND (same tx_data).
  - Otherwise: go to REPORT with error=1.
  - A timeout failure goes directly to the same retry decision, skipping the capture.
- REPORT (1 cycle): result_valid=1 and result_* driven. err_count increments on error and saturates at 255. Then go to SELECT if run=1 and |sensor_en, else go to IDLE.
- rx_done/tx_done outside their wait states are ignored.
- run=0 mid-transaction: the transaction completes through REPORT, then the block goes to IDLE.
- sensor_en changes take effect at the next SELECT only.
- Latency from SEND to result_valid = UART times + 2 cycles (CHECK, REPORT).

Decomposition:
- Package sensor_poll_pkg: state enum, STATE_W, the IDX_W=$clog2(NUM_SENSORS) helper, and err_count saturation constant 8'hFF.
- One sub-module, sensor_rr_pick (combinational round-robin picker). Inputs: en vector, ptr. Outputs: idx, any.

Test Plan:
1. Order and wrap: sensor_en=8'b0000_0101, run=1, UART model replies data=0x3C with crc_ok=1. Required: tx_data sequence 0x00, 0x02, 0x00. First result_valid has sensor=0, data=0x3C, error=0.
2. Checksum retry: crc_ok=0 on first reply, 1 on second. Required: two tx_enable pulses with tx_data=0x00, then one result_valid with error=0 and err_count=0.
3. Timeout exhaustion (TIMEOUT_CYCLES=16, MAX_RETRY=2, no rx_done): required exactly 3 tx_enable pulses spaced by the timeout, then result_error=1 and err_count=1.
4. Stop request: drop run during WAIT_RX, then deliver the reply. Required: the REPORT pulse still occurs, then the block is in IDLE with busy=0 and no further tx_enable.
5. Reset mid-operation: reset=0 for one cycle in WAIT_TX. Required: all outputs are at reset values the next cycle. After release with run=1, the first tx_data=0x00, and a late tx_done causes no transition.
6. Nothing enabled: sensor_en=0, run=1 for 100 cycles. Required: tx_enable never asserted and busy stays 0.
